// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU sharing arbiter: ALU control codes and FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational winner select for the shared ALU: one-hot grant plus index.
// Round-robin from ptr by default; ALU_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  int   idx;
  logic found;

  assign any_valid = |req_valid;

  // Walk the candidates in priority order and keep the first valid one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(ptr) + k) % NUM_REQ;
`endif
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares the single EX-stage ALU between NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [3*NUM_REQ-1:0]      req_ctl,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [2:0]                alu_ctl,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero
);

  state_e              state_q, state_d;
  logic [2:0]          alu_ctl_q, alu_ctl_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     ptr_q, ptr_d;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .ptr       (ptr_q),
    .req_valid (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );
`else
  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_valid (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );
`endif

  always_comb begin
    state_d      = state_q;
    alu_ctl_d    = alu_ctl_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    req_ready    = '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready = grant;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
              alu_ctl_d = req_ctl[3*i +: 3];
              alu_a_d   = req_a[DATA_W*i +: DATA_W];
              alu_b_d   = req_b[DATA_W*i +: DATA_W];
            end
          end
          rsp_id_d = grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d    = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
`endif
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset parks the ALU inputs on a harmless ADD and drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alu_ctl_q    <= ALU_ADD;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign alu_ctl    = alu_ctl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU core and response scoreboard.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [3*NUM_REQ-1:0]      req_ctl;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [2:0]                alu_ctl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] result;
    logic              zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctl    (req_ctl),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_model(input logic [2:0] ctl,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (ctl)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return a << b[4:0];
      3'b110:  return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_model(alu_ctl, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  // Push the expected response when a handshake is seen; pop and compare when it returns.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t got;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id     = ID_W'(i);
          e.result = alu_model(req_ctl[3*i +: 3], req_a[DATA_W*i +: DATA_W],
                               req_b[DATA_W*i +: DATA_W]);
          e.zero   = (e.result == '0);
          sb_q.push_back(e);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        got = '{id: rsp_id, result: rsp_result, zero: rsp_zero};
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got id=%0d result=%h zero=%b, required no response",
                   rsp_id, rsp_result, rsp_zero);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("[TB] FAIL sb_response: got id=%0d result=%h zero=%b, required id=%0d result=%h zero=%b",
                     rsp_id, rsp_result, rsp_zero, e.id, e.result, e.zero);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] ctl,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_ctl[3*i +: 3]         = ctl;
    req_a[DATA_W*i +: DATA_W] = a;
    req_b[DATA_W*i +: DATA_W] = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_ctl   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: got valid=%b id=%0d result=%h zero=%b, required all zero",
               rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    checks++;
    if (alu_ctl !== 3'b010) begin
      errors++;
      $display("[TB] FAIL reset_alu_ctl: got %b, required 010", alu_ctl);
    end
    checks++;
    if ({alu_a, alu_b} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_alu_ops: got a=%h b=%h, required 0", alu_a, alu_b);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, required 00", req_ready);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    step();
    set_req(0, 3'b010, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b, required 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_ctl, alu_a, alu_b} !== {1'b0, 3'b010, 32'd5, 32'd7}) begin
      errors++;
      $display("[TB] FAIL single_exec: got valid=%b ctl=%b a=%h b=%h, required valid=0 ctl=010 a=5 b=7",
               rsp_valid, alu_ctl, alu_a, alu_b);
    end
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_rsp: got valid=%b id=%0d result=%h zero=%b, required 1/0/c/0",
               rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_rsp_clear: got %b, required 0", rsp_valid);
    end
  endtask

  task automatic test_beq_sub();
    step();
    set_req(1, 3'b110, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL beq_ready: got %b, required 10", req_ready);
    end
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL beq_rsp: got valid=%b id=%0d result=%h zero=%b, required 1/1/0/1",
               rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    step();
  endtask

  task automatic test_contention();
    int last   = -1;
    int cyc    = 0;
    int grants = 0;
    logic [NUM_REQ-1:0] exp_grant;
    step();
    set_req(0, 3'b010, 32'd100, 32'd1);
    set_req(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    while (grants < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready !== 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_grant = 2'b01;
`else
        exp_grant = (grants % 2 == 0) ? 2'b01 : 2'b10;
`endif
        checks++;
        if (req_ready !== exp_grant) begin
          errors++;
          $display("[TB] FAIL contention_grant%0d: got %b, required %b", grants, req_ready, exp_grant);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("[TB] FAIL contention_interval: got %0d cycles, required 3", cyc - last);
          end
        end
        last = cyc;
        grants++;
      end
    end
    checks++;
    if (grants < 6) begin
      errors++;
      $display("[TB] FAIL contention_timeout: got %0d grants, required 6", grants);
    end
    step();
    req_valid = 2'b00;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    step();
    set_req(0, 3'b000, 32'h0000_F0F0, 32'h0000_FF00);
    set_req(1, 3'b110, 32'd10, 32'd3);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_ready: got %b, required 01", req_ready);
    end
    step();
    req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_exec_ready: got %b, required 00", req_ready);
    end
    step();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready} !==
          {1'b1, 1'b0, 32'h0000_F000, 1'b0, 2'b00}) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b id=%0d result=%h zero=%b ready=%b, required 1/0/f000/0/00",
                 n, rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready);
      end
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b, required valid=0 ready=10",
               rsp_valid, req_ready);
    end
    step();
    req_valid = 2'b00;
    repeat (3) step();
  endtask

  task automatic test_reset_mid_resp();
    step();
    set_req(0, 3'b010, 32'd1, 32'd1);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmr_pre: got rsp_valid=%b, required 1", rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_zero, alu_ctl, alu_a, req_ready} !==
        {1'b0, 32'd0, 1'b0, 3'b010, 32'd0, 2'b00}) begin
      errors++;
      $display("[TB] FAIL rmr_async: got valid=%b result=%h zero=%b ctl=%b a=%h ready=%b, required 0/0/0/010/0/00",
               rsp_valid, rsp_result, rsp_zero, alu_ctl, alu_a, req_ready);
    end
    @(negedge clk);
    step();
    rst_n     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rmr_after: got ready=%b, required 01", req_ready);
    end
    step();
    req_valid = 2'b00;
    repeat (3) step();
  endtask

  task automatic test_pass_through();
    step();
    set_req(0, 3'b011, 32'd1, 32'd3);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({alu_ctl, alu_a, alu_b} !== {3'b011, 32'd1, 32'd3}) begin
      errors++;
      $display("[TB] FAIL pass_exec: got ctl=%b a=%h b=%h, required 011/1/3", alu_ctl, alu_a, alu_b);
    end
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_result} !== {1'b1, 32'd8}) begin
      errors++;
      $display("[TB] FAIL pass_rsp: got valid=%b result=%h, required 1/8", rsp_valid, rsp_result);
    end
    step();
    set_req(1, 3'b111, 32'd5, 32'd9);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (alu_ctl !== 3'b111) begin
      errors++;
      $display("[TB] FAIL pass_undef_ctl: got %b, required 111", alu_ctl);
    end
    step();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pass_undef_rsp: got valid=%b id=%0d result=%h zero=%b, required 1/1/0/1",
               rsp_valid, rsp_id, rsp_result, rsp_zero);
    end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_beq_sub();
    test_contention();
    test_backpressure();
    test_reset_mid_resp();
    test_pass_through();
    repeat (2) step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d pending responses, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
